fetch_execute_pipe_ctrl: RTL and testbench
==========================================

# fetch_execute_pipe_ctrl

Controller for the fetch→execute pipeline boundary: owns the fetch/execute latch (pc, instr, npc, prediction), sequences it with a valid/ready handshake, and absorbs execute back-pressure in a 2-entry skid buffer so fetch sees a registered ready. It sits between the fetch stage and the execute stage. The hazard unit drives its flush input. When no valid instruction is held, it presents a NOP bubble to execute.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0013, instruction word presented to execute when no valid entry is held (addi x0,x0,0)
- STALL_CNT_W, 16, width of saturating stall counter

Ports:
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents a valid instruction
- if_pc, if_instr, if_npc, if_prediction  in  32 each  fetch payload
- if_ready  out  1  buffer can accept; registered (state != FULL)
- ex_ready  in  1  execute consumes head entry this cycle (low = stall)
- flush  in  1  discard all held/incoming entries (mispredict, exception)
- ex_valid  out  1  head entry valid (state != EMPTY)
- ex_pc, ex_npc, ex_prediction  out  32 each  head entry payload
- ex_instr  out  32  head instr when ex_valid, else NOP_INSTR
- stall_count  out  STALL_CNT_W  cycles with ex_valid & !ex_ready, saturating

## Operation
- Storage: main register M (head, drives ex_*) and skid register S; occupancy state EMPTY / ONE / FULL.
- Accept = if_valid & if_ready; Retire = ex_valid & ex_ready.
- EMPTY: accept → ONE, M ← input.
- ONE: accept & retire → ONE, M ← input; accept & !retire → FULL, S ← input; !accept & retire → EMPTY; neither → ONE, hold.
- FULL: if_ready=0, no accept; retire → ONE, M ← S; else hold.
- flush (synchronous, highest priority): next state EMPTY regardless of accept/retire; the entry accepted in the flush cycle is discarded; M/S contents need not be cleared.
- Entries retire in strict arrival order; no entry dropped or duplicated except by flush.
- ex_instr = ex_valid ? M.instr : NOP_INSTR; ex_pc/ex_npc/ex_prediction show M regardless of ex_valid.
- stall_count increments when ex_valid & !ex_ready, saturating at all-ones; not cleared by flush; cleared only by reset.

## Timing
- Reset (nRST low, async): state EMPTY; M, S, stall_count = 0; ex_valid=0; ex_instr=NOP_INSTR; ex_pc/ex_npc/ex_prediction=0; if_ready=1 after release.
- Latency: an entry accepted in cycle N is visible on ex_* with ex_valid=1 in cycle N+1 when buffer was EMPTY, or when ONE with retire in cycle N.
- Throughput: one entry per cycle sustained while ex_ready=1.
- if_ready depends only on registered state; it does not combinationally depend on ex_ready, avoiding a ready path through the stage.
- Stall at ONE with a new accept fills S; if_ready drops the following cycle; no data lost.
- Flush asserted in cycle N: ex_valid=0 and if_ready=1 in cycle N+1; ex_instr=NOP_INSTR in N+1.
- Flush while ex_ready=1 in cycle N: head still counts as retired in N (execute saw it); nothing else survives.
- nRST asserted mid-transfer: all state is lost immediately; the entry in flight is dropped.

## Test plan
- Reset: hold nRST low, release → ex_valid=0, ex_instr=32'h13, if_ready=1, stall_count=0.
- Streaming: ex_ready=1, feed pc 0x100,0x104,0x108 on consecutive cycles → ex_pc 0x100,0x104,0x108 on the following consecutive cycles; if_ready stays 1.
- Back-pressure: ex_ready=0, feed 0x200 then 0x204 → state FULL, if_ready=0, ex_pc=0x200; raise ex_ready → 0x200 then 0x204 retire in order; stall_count equals the number of stalled cycles.
- Flush: buffer FULL (0x300,0x304), assert flush together with if_valid (0x308) → next cycle ex_valid=0, ex_instr=0x13, if_ready=1; 0x300/0x304/0x308 never retire.
- Saturation: STALL_CNT_W=4, stall 20 cycles → stall_count=4'hF and holds.
- Async reset mid-stall: FULL state, pulse nRST low between clock edges → outputs go to reset values immediately, not at the next edge.

Source files
------------

// File: rtl/fetch_execute_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_execute_pipe_ctrl
// Purpose  : Fetch->execute pipeline latch controller. Holds the head entry
//            (main register M) plus one skid entry (S), so the ready returned
//            to fetch is a registered signal. Presents a NOP bubble to
//            execute whenever no valid entry is held, and counts stall cycles.
// Ports    : CLK, nRST         - clock, asynchronous active-low reset
//            if_valid/if_*     - fetch payload in (pc, instr, npc, prediction)
//            if_ready          - registered: buffer is not full
//            ex_ready          - execute consumes the head entry this cycle
//            flush             - drop every held and incoming entry
//            ex_valid/ex_*     - head entry out (ex_instr = NOP when invalid)
//            stall_count       - saturating count of ex_valid & !ex_ready
// Revision : 1.0 - initial release
// ============================================================================
module fetch_execute_pipe_ctrl #(
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   if_valid,
  input  logic [31:0]            if_pc,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_npc,
  input  logic [31:0]            if_prediction,
  output logic                   if_ready,
  input  logic                   ex_ready,
  input  logic                   flush,
  output logic                   ex_valid,
  output logic [31:0]            ex_pc,
  output logic [31:0]            ex_instr,
  output logic [31:0]            ex_npc,
  output logic [31:0]            ex_prediction,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] pred;
  } entry_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [STALL_CNT_W-1:0] C_CNT_ONE = STALL_CNT_W'(1);

  logic [1:0]             state_q, state_d;
  entry_t                 m_q, s_q, w_in;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic w_accept, w_retire, w_stall;
  logic w_m_load_in, w_m_load_s, w_s_load;

  assign w_in = '{pc: if_pc, instr: if_instr, npc: if_npc, pred: if_prediction};

  // Both handshake signals come straight from the state register, so no
  // combinational ready path runs from execute back to fetch.
  assign if_ready = (state_q != ST_FULL);
  assign ex_valid = (state_q != ST_EMPTY);

  assign w_accept = if_valid & if_ready;
  assign w_retire = ex_valid & ex_ready;
  assign w_stall  = ex_valid & ~ex_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; flush overrides any accept/retire activity.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (w_accept) state_d = ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_retire)      state_d = ST_FULL;
          else if (!w_accept && w_retire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (w_retire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath load controls. Loads are suppressed during flush because the
  // contents are dead once the buffer empties.
  // --------------------------------------------------------------------------
  always_comb begin
    w_m_load_in = 1'b0;
    w_m_load_s  = 1'b0;
    w_s_load    = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: w_m_load_in = w_accept;
        ST_ONE: begin
          w_m_load_in = w_accept & w_retire;
          w_s_load    = w_accept & ~w_retire;
        end
        ST_FULL:  w_m_load_s = w_retire;
        default: begin
          w_m_load_in = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (w_m_load_in)     m_q <= w_in;
      else if (w_m_load_s) m_q <= s_q;
      if (w_s_load)        s_q <= w_in;
    end
  end

  // --------------------------------------------------------------------------
  // Stall counter: saturates at all-ones, survives flush.
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + C_CNT_ONE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_pc         = m_q.pc;
  assign ex_npc        = m_q.npc;
  assign ex_prediction = m_q.pred;
  assign ex_instr      = ex_valid ? m_q.instr : NOP_INSTR;
  assign stall_count   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_execute_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_execute_pipe_ctrl
// Purpose  : Self-checking bench for fetch_execute_pipe_ctrl. A default
//            instance and a 4-bit stall-counter instance share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_execute_pipe_ctrl;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0, if_instr = '0, if_npc = '0, if_prediction = '0;
  logic        ex_ready = 1'b0;
  logic        flush = 1'b0;

  logic        if_ready, ex_valid;
  logic [31:0] ex_pc, ex_instr, ex_npc, ex_prediction;
  logic [15:0] stall_count;

  logic        if_ready4, ex_valid4;
  logic [31:0] ex_pc4, ex_instr4, ex_npc4, ex_prediction4;
  logic [3:0]  stall_count4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  fetch_execute_pipe_ctrl dut (
    .CLK(CLK), .nRST(nRST), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .if_npc(if_npc), .if_prediction(if_prediction),
    .if_ready(if_ready), .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_npc(ex_npc),
    .ex_prediction(ex_prediction), .stall_count(stall_count)
  );

  fetch_execute_pipe_ctrl #(.STALL_CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .if_npc(if_npc), .if_prediction(if_prediction),
    .if_ready(if_ready4), .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid4), .ex_pc(ex_pc4), .ex_instr(ex_instr4), .ex_npc(ex_npc4),
    .ex_prediction(ex_prediction4), .stall_count(stall_count4)
  );

  // Payload fields are derived from pc so any field mix-up is visible.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h5A00_0033;
  endfunction
  function automatic logic [31:0] npc_of(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
  function automatic logic [31:0] pred_of(input logic [31:0] pc);
    return ~pc;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_head(input logic valid, input logic [31:0] pc, input logic chk_pc);
    chk("ex_valid", 64'(ex_valid), 64'(valid));
    if (valid) begin
      chk("ex_pc",         64'(ex_pc),         64'(pc));
      chk("ex_instr",      64'(ex_instr),      64'(instr_of(pc)));
      chk("ex_npc",        64'(ex_npc),        64'(npc_of(pc)));
      chk("ex_prediction", 64'(ex_prediction), 64'(pred_of(pc)));
    end else begin
      chk("ex_instr_nop", 64'(ex_instr), 64'(C_NOP));
      if (chk_pc) chk("ex_pc_idle", 64'(ex_pc), 64'(pc));
    end
  endtask

  task automatic check_stall(input int exp);
    int e16, e4;
    e16 = (exp > 65535) ? 65535 : exp;
    e4  = (exp > 15) ? 15 : exp;
    chk("stall_count",   64'(stall_count),  64'(e16));
    chk("stall_count_4", 64'(stall_count4), 64'(e4));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    if_valid      = v;
    if_pc         = pc;
    if_instr      = instr_of(pc);
    if_npc        = npc_of(pc);
    if_prediction = pred_of(pc);
    ex_ready      = rdy;
    flush         = fl;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic        fl;
    logic        e_valid;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic        e_ifr;
    int          e_st;
  } vec_t;

  vec_t vecs[16];

  // Reference model: an ordered list of held pcs plus an unbounded stall tally.
  logic [31:0] mq[$];
  int          m_stall;

  initial begin
    // ---------------- table: streaming, back-pressure, flush ----------------
    vecs[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 0};
    vecs[1]  = '{1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 1'b1, 0};
    vecs[2]  = '{1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 0};
    vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h108, 1'b1, 0};
    vecs[4]  = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 0};
    vecs[5]  = '{1'b1, 32'h204, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1};
    vecs[6]  = '{1'b1, 32'h208, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 2};
    vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h204, 1'b1, 2};
    vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h204, 1'b1, 2};
    vecs[9]  = '{1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 2};
    vecs[10] = '{1'b1, 32'h304, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 3};
    vecs[11] = '{1'b1, 32'h308, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 4};
    vecs[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 4};
    vecs[13] = '{1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 4};
    vecs[14] = '{1'b1, 32'h404, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 4};
    vecs[15] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 4};

    // ---------------- reset ----------------
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check_head(1'b0, 32'h0, 1'b1);
    chk("ex_npc_rst",  64'(ex_npc),        64'h0);
    chk("ex_pred_rst", 64'(ex_prediction), 64'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    chk("if_ready_rst", 64'(if_ready), 64'h1);
    check_stall(0);

    // ---------------- table-driven sequence ----------------
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].rdy, vecs[i].fl);
      @(posedge CLK);
      #1;
      check_head(vecs[i].e_valid, vecs[i].e_pc, vecs[i].chk_pc);
      chk($sformatf("if_ready[%0d]", i), 64'(if_ready), 64'(vecs[i].e_ifr));
      check_stall(vecs[i].e_st);
    end

    // ---------------- saturation: 20 stalled cycles from here ----------------
    drive(1'b1, 32'h500, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check_stall(4);
    drive(1'b1, 32'h504, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check_stall(5);
    chk("if_ready_full", 64'(if_ready), 64'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      @(posedge CLK); #1;
      if (i == 10) check_stall(16);
    end
    check_stall(24);
    check_head(1'b1, 32'h500, 1'b1);

    // ---------------- async reset between edges, FULL state ----------------
    #2;
    nRST = 1'b0;
    #1;
    check_head(1'b0, 32'h0, 1'b1);
    chk("if_ready_async", 64'(if_ready), 64'h1);
    check_stall(0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    check_head(1'b0, 32'h0, 1'b1);

    // ---------------- randomized against the queue model ----------------
    m_stall = 0;
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic v, rdy, fl, acc, ret;
      logic [31:0] pc;
      v   = ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < 55);
      fl  = ($urandom_range(0, 99) < 4);
      pc  = $urandom & 32'hFFFF_FFFC;
      drive(v, pc, rdy, fl);
      @(posedge CLK);
      acc = v && (mq.size() < 2);
      ret = (mq.size() > 0) && rdy;
      if ((mq.size() > 0) && !rdy) m_stall++;
      if (fl) begin
        mq.delete();
      end else begin
        if (ret) void'(mq.pop_front());
        if (acc) mq.push_back(pc);
      end
      #1;
      if (mq.size() > 0) check_head(1'b1, mq[0], 1'b0);
      else               check_head(1'b0, 32'h0, 1'b0);
      chk("if_ready_rand", 64'(if_ready), 64'(mq.size() < 2));
      check_stall(m_stall);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
